// File: rtl/player_move_ctrl.sv
// player_move_ctrl: turns the held-arrow vector from the keyboard decoder into
// a grid position. Steps once on press, auto-repeats after a hold delay, and
// clamps at the grid edges (or wraps when WRAP_AROUND_EN is defined).
// Optional feature macro: WRAP_AROUND_EN.
module player_move_ctrl #(
   parameter int XW            = 4,
   parameter int YW            = 4,
   parameter int X_MAX         = 15,
   parameter int Y_MAX         = 11,
   parameter int X_INIT        = 0,
   parameter int Y_INIT        = 0,
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000,
   parameter int CNT_W         = 25
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    nums,
   input  logic          en,
   output logic [XW-1:0] pos_x,
   output logic [YW-1:0] pos_y,
   output logic          moved
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   localparam logic signed [1:0] D_POS  = 2'sb01;
   localparam logic signed [1:0] D_NEG  = 2'sb11;
   localparam logic signed [1:0] D_ZERO = 2'sb00;

   localparam logic [XW-1:0]    X_MAX_V   = XW'(X_MAX);
   localparam logic [YW-1:0]    Y_MAX_V   = YW'(Y_MAX);
   localparam logic [XW-1:0]    X_INIT_V  = XW'(X_INIT);
   localparam logic [YW-1:0]    Y_INIT_V  = YW'(Y_INIT);
   localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   timer, timer_nxt;
   logic signed [1:0]  ldx, ldy, ldx_nxt, ldy_nxt;
   logic signed [1:0]  dx, dy;
   logic               active, dir_chg, do_step;
   logic [XW-1:0]      nx;
   logic [YW-1:0]      ny;

   // Next x for one step in direction d: clamp at the edges, or wrap.
   function automatic logic [XW-1:0] step_x(input logic [XW-1:0] p,
                                            input logic signed [1:0] d);
      logic [XW-1:0] r;
      r = p;
      if (d == D_POS) begin
         if (p == X_MAX_V) begin
`ifdef WRAP_AROUND_EN
            r = '0;
`else
            r = p;
`endif
         end else begin
            r = p + 1'b1;
         end
      end else if (d == D_NEG) begin
         if (p == '0) begin
`ifdef WRAP_AROUND_EN
            r = X_MAX_V;
`else
            r = p;
`endif
         end else begin
            r = p - 1'b1;
         end
      end
      return r;
   endfunction

   // Next y for one step in direction d: clamp at the edges, or wrap.
   function automatic logic [YW-1:0] step_y(input logic [YW-1:0] p,
                                            input logic signed [1:0] d);
      logic [YW-1:0] r;
      r = p;
      if (d == D_POS) begin
         if (p == Y_MAX_V) begin
`ifdef WRAP_AROUND_EN
            r = '0;
`else
            r = p;
`endif
         end else begin
            r = p + 1'b1;
         end
      end else if (d == D_NEG) begin
         if (p == '0) begin
`ifdef WRAP_AROUND_EN
            r = Y_MAX_V;
`else
            r = p;
`endif
         end else begin
            r = p - 1'b1;
         end
      end
      return r;
   endfunction

   // Effective direction: opposing keys cancel on their own axis only.
   always_comb begin
      dx = D_ZERO;
      dy = D_ZERO;
      if (nums[0] && !nums[1])      dx = D_POS;
      else if (nums[1] && !nums[0]) dx = D_NEG;
      if (nums[2] && !nums[3])      dy = D_POS;
      else if (nums[3] && !nums[2]) dy = D_NEG;
      active  = (dx != D_ZERO) || (dy != D_ZERO);
      dir_chg = (dx != ldx) || (dy != ldy);
      nx      = step_x(pos_x, dx);
      ny      = step_y(pos_y, dy);
   end

   // Next-state logic: decides when to step and runs the hold/repeat timer.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      ldx_nxt   = ldx;
      ldy_nxt   = ldy;
      do_step   = 1'b0;
      unique case (state)
         IDLE: begin
            if (en && active) begin
               do_step   = 1'b1;
               state_nxt = HOLD;
               timer_nxt = '0;
            end
         end
         HOLD: begin
            if (!active || !en) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (dir_chg) begin
               do_step   = 1'b1;
               timer_nxt = '0;
            end else if (timer == HOLD_TC) begin
               do_step   = 1'b1;
               state_nxt = REPEAT;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         REPEAT: begin
            if (!active || !en) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (dir_chg) begin
               do_step   = 1'b1;
               state_nxt = HOLD;
               timer_nxt = '0;
            end else if (timer == REPEAT_TC) begin
               do_step   = 1'b1;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      endcase
      if (do_step) begin
         ldx_nxt = dx;
         ldy_nxt = dy;
      end
   end

   // FSM state, timer and latched direction registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         ldx   <= D_ZERO;
         ldy   <= D_ZERO;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         ldx   <= ldx_nxt;
         ldy   <= ldy_nxt;
      end
   end

   // Position registers; moved flags only steps that changed the position.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x <= X_INIT_V;
         pos_y <= Y_INIT_V;
         moved <= 1'b0;
      end else begin
         if (do_step) begin
            pos_x <= nx;
            pos_y <= ny;
         end
         moved <= do_step && ((nx != pos_x) || (ny != pos_y));
      end
   end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Testbench for player_move_ctrl: scenario tasks plus a behavioural reference
// model feeding an expected-result queue that is checked after every edge.
module tb_player_move_ctrl;

   localparam int HOLD = 4;
   localparam int REP  = 2;
   localparam int XMAX = 3;
   localparam int YMAX = 3;
`ifdef WRAP_AROUND_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] nums = 4'b0000;
   logic [3:0] pos_x;
   logic [3:0] pos_y;
   logic       moved;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int    x;
      int    y;
      int    mv;
      string tag;
   } exp_t;
   exp_t sb[$];

   // reference model state
   int m_x = 0, m_y = 0, m_st = 0, m_t = 0, m_ldx = 0, m_ldy = 0, m_mv = 0;
   // last observed outputs
   int ox, oy, om;

   player_move_ctrl #(
      .XW(4), .YW(4), .X_MAX(XMAX), .Y_MAX(YMAX), .X_INIT(0), .Y_INIT(0),
      .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(3)
   ) dut (
      .clk(clk), .rst(rst), .nums(nums), .en(en),
      .pos_x(pos_x), .pos_y(pos_y), .moved(moved)
   );

   always #5 clk = ~clk;

   function automatic int m_axis(input int p, input int d, input int mx);
      if (d == 1)  return (p == mx) ? (WRAP ? 0 : p) : p + 1;
      if (d == -1) return (p == 0) ? (WRAP ? mx : p) : p - 1;
      return p;
   endfunction

   // Drive one cycle, predict the result, then compare after the edge.
   task automatic cycle(input logic r, input logic e, input logic [3:0] n, input string tag);
      int dx, dy, nx, ny, term;
      bit act, stp;
      exp_t ex, got;
      rst = r; en = e; nums = n;
      dx = (n[0] && !n[1]) ? 1 : ((n[1] && !n[0]) ? -1 : 0);
      dy = (n[2] && !n[3]) ? 1 : ((n[3] && !n[2]) ? -1 : 0);
      act = (dx != 0) || (dy != 0);
      stp = 1'b0;
      if (r) begin
         m_x = 0; m_y = 0; m_st = 0; m_t = 0; m_ldx = 0; m_ldy = 0; m_mv = 0;
      end else begin
         if (m_st == 0) begin
            if (e && act) begin stp = 1'b1; m_st = 1; m_t = 0; end
         end else begin
            term = (m_st == 1) ? HOLD - 1 : REP - 1;
            if (!act || !e) begin
               m_st = 0; m_t = 0;
            end else if (dx != m_ldx || dy != m_ldy) begin
               stp = 1'b1; m_st = 1; m_t = 0;
            end else if (m_t == term) begin
               stp = 1'b1; m_st = 2; m_t = 0;
            end else begin
               m_t++;
            end
         end
         m_mv = 0;
         if (stp) begin
            m_ldx = dx; m_ldy = dy;
            nx = m_axis(m_x, dx, XMAX);
            ny = m_axis(m_y, dy, YMAX);
            m_mv = (nx != m_x || ny != m_y) ? 1 : 0;
            m_x = nx; m_y = ny;
         end
      end
      ex.x = m_x; ex.y = m_y; ex.mv = m_mv; ex.tag = tag;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      ox = int'(pos_x); oy = int'(pos_y); om = int'(moved);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         got = sb.pop_front();
         if (ox !== got.x || oy !== got.y || om !== got.mv) begin
            errors++;
            $display("FAIL %s: got (%0d,%0d) moved=%0d, expected (%0d,%0d) moved=%0d",
                     got.tag, ox, oy, om, got.x, got.y, got.mv);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 4'b0001, "reset");
         checks++;
         if (pos_x !== 4'd0 || pos_y !== 4'd0 || moved !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: got (%0d,%0d) moved=%0d, expected (0,0) moved=0",
                     pos_x, pos_y, moved);
         end
      end
   endtask

   task automatic test_hold_repeat();
      int exp9x, exp9m;
      exp9x = WRAP ? 0 : 3;
      exp9m = WRAP ? 1 : 0;
      for (int e = 1; e <= 9; e++) begin
         cycle(1'b0, 1'b1, 4'b0001, "hold_repeat");
         if (e == 1 || e == 5 || e == 7) begin
            checks++;
            if (ox !== (e == 1 ? 1 : (e == 5 ? 2 : 3)) || om !== 1) begin
               errors++;
               $display("FAIL hold_repeat_e%0d: got x=%0d moved=%0d", e, ox, om);
            end
         end else if (e == 9) begin
            checks++;
            if (ox !== exp9x || om !== exp9m) begin
               errors++;
               $display("FAIL edge_e9: got x=%0d moved=%0d, expected x=%0d moved=%0d",
                        ox, om, exp9x, exp9m);
            end
         end
      end
      cycle(1'b0, 1'b1, 4'b0000, "release");
   endtask

   task automatic test_cancel_diag();
      cycle(1'b1, 1'b1, 4'b0000, "rst");
      cycle(1'b0, 1'b1, 4'b0101, "diag_dr");
      cycle(1'b0, 1'b1, 4'b0000, "release");
      cycle(1'b0, 1'b1, 4'b1001, "diag_ur");
      checks++;
      if (ox !== 2 || oy !== 0 || om !== 1) begin
         errors++;
         $display("FAIL diag_ur: got (%0d,%0d) moved=%0d, expected (2,0) moved=1", ox, oy, om);
      end
      cycle(1'b0, 1'b1, 4'b0000, "release");
      cycle(1'b1, 1'b1, 4'b0000, "rst");
      cycle(1'b0, 1'b1, 4'b1100, "cancel_ud");
      cycle(1'b0, 1'b1, 4'b1100, "cancel_ud");
      checks++;
      if (ox !== 0 || oy !== 0 || om !== 0) begin
         errors++;
         $display("FAIL cancel_ud: got (%0d,%0d) moved=%0d, expected (0,0) moved=0", ox, oy, om);
      end
      cycle(1'b0, 1'b1, 4'b0000, "release");
      cycle(1'b0, 1'b1, 4'b1101, "cancel_right");
      checks++;
      if (ox !== 1 || oy !== 0 || om !== 1) begin
         errors++;
         $display("FAIL cancel_right: got (%0d,%0d) moved=%0d, expected (1,0) moved=1", ox, oy, om);
      end
      cycle(1'b0, 1'b1, 4'b0000, "release");
   endtask

   task automatic test_dir_switch();
      cycle(1'b1, 1'b1, 4'b0000, "rst");
      cycle(1'b0, 1'b1, 4'b0001, "right");
      cycle(1'b0, 1'b1, 4'b0000, "release");
      cycle(1'b0, 1'b1, 4'b0001, "right");
      cycle(1'b0, 1'b1, 4'b0001, "right");
      cycle(1'b0, 1'b1, 4'b0010, "switch_left");
      checks++;
      if (ox !== 1 || om !== 1) begin
         errors++;
         $display("FAIL switch_left: got x=%0d moved=%0d, expected x=1 moved=1", ox, om);
      end
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b0, 1'b1, 4'b0010, "left_hold");
         checks++;
         if (om !== (i == 4 ? 1 : 0) || ox !== (i == 4 ? 0 : 1)) begin
            errors++;
            $display("FAIL left_hold_%0d: got x=%0d moved=%0d", i, ox, om);
         end
      end
      cycle(1'b0, 1'b1, 4'b0000, "release");
   endtask

   task automatic test_en_drop();
      cycle(1'b1, 1'b1, 4'b0000, "rst");
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'b0001, "to_repeat");
      cycle(1'b0, 1'b0, 4'b0001, "en_low");
      checks++;
      if (ox !== 2 || om !== 0) begin
         errors++;
         $display("FAIL en_low: got x=%0d moved=%0d, expected x=2 moved=0", ox, om);
      end
      cycle(1'b0, 1'b1, 4'b0001, "en_rise");
      checks++;
      if (ox !== 3 || om !== 1) begin
         errors++;
         $display("FAIL en_rise: got x=%0d moved=%0d, expected x=3 moved=1", ox, om);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'b0001, "after_en");
      cycle(1'b0, 1'b1, 4'b0000, "release");
   endtask

   task automatic test_rst_mid_repeat();
      cycle(1'b1, 1'b1, 4'b0000, "rst");
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 4'b0101, "diag_repeat");
      checks++;
      if (ox !== 2 || oy !== 2) begin
         errors++;
         $display("FAIL pre_rst_pos: got (%0d,%0d), expected (2,2)", ox, oy);
      end
      cycle(1'b1, 1'b1, 4'b0101, "rst_mid");
      checks++;
      if (ox !== 0 || oy !== 0 || om !== 0) begin
         errors++;
         $display("FAIL rst_mid: got (%0d,%0d) moved=%0d, expected (0,0) moved=0", ox, oy, om);
      end
      cycle(1'b0, 1'b1, 4'b0101, "post_rst");
      checks++;
      if (ox !== 1 || oy !== 1 || om !== 1) begin
         errors++;
         $display("FAIL post_rst: got (%0d,%0d) moved=%0d, expected (1,1) moved=1", ox, oy, om);
      end
      cycle(1'b0, 1'b1, 4'b0000, "release");
   endtask

   task automatic test_random();
      logic [3:0] n;
      logic e, r;
      n = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) n = 4'($urandom_range(0, 15));
         e = ($urandom_range(0, 15) != 0);
         r = ($urandom_range(0, 63) == 0);
         cycle(r, e, n, "random");
      end
   endtask

   initial begin
      test_reset();
      test_hold_repeat();
      test_cancel_diag();
      test_dir_switch();
      test_en_drop();
      test_rst_mid_repeat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
